// File: rtl/spi_cfg_sequencer.sv
// SPI write sequencer: round-robin arbitration between two requesters and
// serialisation of each accepted write into a 16-bit mode-0 frame.
module spi_cfg_sequencer #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned IDLE_GAP = 4,
  parameter int unsigned MAX_ADDR = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a_valid,
  input  logic [6:0] req_a_addr,
  input  logic [7:0] req_a_data,
  output logic       req_a_ready,
  input  logic       req_b_valid,
  input  logic [6:0] req_b_addr,
  input  logic [7:0] req_b_data,
  output logic       req_b_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic                 last_b_q, last_b_d;
  logic                 sclk_d, copi_d, ncs_d, busy_d, done_d, err_d;

  logic                 grant_a, grant_b, accept, legal;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_data;

  // Grant goes to the sole requester, or to the one not served last.
  always_comb begin
    grant_a  = (state_q == IDLE) && req_a_valid && (!req_b_valid || last_b_q);
    grant_b  = (state_q == IDLE) && req_b_valid && (!req_a_valid || !last_b_q);
    accept   = grant_a || grant_b;
    sel_addr = grant_b ? req_b_addr : req_a_addr;
    sel_data = grant_b ? req_b_data : req_a_data;
    legal    = (sel_addr <= ADDR_W'(MAX_ADDR));
  end

  assign req_a_ready = grant_a;
  assign req_b_ready = grant_b;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    last_b_d = last_b_q;
    sclk_d   = SCLK;
    copi_d   = COPI;
    ncs_d    = nCS;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          last_b_d = grant_b;
          if (legal) begin
            shreg_d = {1'b1, sel_addr, sel_data};
            copi_d  = 1'b1;
            ncs_d   = 1'b0;
            cnt_d   = '0;
            bit_d   = '0;
            state_d = SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        // COPI advances only together with the SCLK falling edge.
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (SCLK) begin
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
            copi_d  = shreg_q[FRAME_W-2];
          end else if (bit_q == BIT_W'(FRAME_W - 1)) begin
            state_d = HOLD;
          end else begin
            sclk_d = 1'b1;
            bit_d  = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          cnt_d   = '0;
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(IDLE_GAP - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // All SPI pins and status outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      last_b_q <= 1'b1;
      SCLK     <= 1'b0;
      COPI     <= 1'b0;
      nCS      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      last_b_q <= last_b_d;
      SCLK     <= sclk_d;
      COPI     <= copi_d;
      nCS      <= ncs_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Bench for spi_cfg_sequencer: SPI wire monitor with expected-frame scoreboard,
// register-bank model, and a second instance with fast timing parameters.
module tb_spi_cfg_sequencer;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_HOLD  = 2;
  localparam int unsigned IDLE_GAP = 4;
  localparam int unsigned NCS_LOW  = CS_SETUP + 32 * CLK_DIV + CS_HOLD;
  localparam int unsigned S_NCS_LOW = 1 + 32 * 2 + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic [6:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       busy, done, err, sclk, copi, ncs;

  logic       s_valid, s_ready, s_b_valid, s_b_ready;
  logic [6:0] s_addr, s_b_addr;
  logic [7:0] s_data, s_b_data;
  logic       s_busy, s_done, s_err, s_sclk, s_copi, s_ncs;

  always #5 clk = ~clk;

  spi_cfg_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_a_valid(a_valid), .req_a_addr(a_addr), .req_a_data(a_data), .req_a_ready(a_ready),
    .req_b_valid(b_valid), .req_b_addr(b_addr), .req_b_data(b_data), .req_b_ready(b_ready),
    .busy(busy), .done(done), .err(err), .SCLK(sclk), .COPI(copi), .nCS(ncs)
  );

  spi_cfg_sequencer #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .req_a_valid(s_valid), .req_a_addr(s_addr), .req_a_data(s_data), .req_a_ready(s_ready),
    .req_b_valid(s_b_valid), .req_b_addr(s_b_addr), .req_b_data(s_b_data), .req_b_ready(s_b_ready),
    .busy(s_busy), .done(s_done), .err(s_err), .SCLK(s_sclk), .COPI(s_copi), .nCS(s_ncs)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_s[$];
  logic [7:0]  regs [0:127];
  bit          last_b_model = 1'b1;

  logic        p_sclk, p_ncs, p_copi, in_frame, done_exp;
  logic [15:0] shv, got;
  int          nbits, low_len, high_run, gap_len, frames_done = 0;

  // Wire-level monitor on the main instance; pops the scoreboard at each nCS rise.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0; nbits = 0; low_len = 0; high_run = 0; gap_len = 100;
      p_sclk = 1'b0; p_ncs = 1'b1; p_copi = 1'b0;
      for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    end else begin
      if (a_ready && b_ready) begin
        miscompares++; $display("FAIL both_ready: a_ready=%b b_ready=%b, required at most one", a_ready, b_ready);
      end
      if ((a_ready && !a_valid) || (b_ready && !b_valid)) begin
        miscompares++; $display("FAIL ready_without_valid: a=%b/%b b=%b/%b", a_ready, a_valid, b_ready, b_valid);
      end
      if (ncs && (sclk !== p_sclk)) begin
        miscompares++; $display("FAIL sclk_edge_cs_high: sclk %b->%b while nCS=1", p_sclk, sclk);
      end
      if (sclk && p_sclk && (copi !== p_copi)) begin
        miscompares++; $display("FAIL copi_stable: copi %b->%b during SCLK high", p_copi, copi);
      end
      done_exp = ncs && !p_ncs && in_frame;
      if (done !== done_exp) begin
        miscompares++; $display("FAIL done_pulse: done=%b required %b", done, done_exp);
      end
      if (!ncs && p_ncs) begin
        vectors++;
        if (gap_len < int'(IDLE_GAP)) begin
          miscompares++; $display("FAIL idle_gap: %0d nCS-high cycles, required >= %0d", gap_len, IDLE_GAP);
        end
        in_frame = 1'b1; nbits = 0; low_len = 0; shv = 16'h0;
      end
      if (!ncs) low_len++;
      if (sclk && !p_sclk) begin
        shv = {shv[14:0], copi}; nbits++; high_run = 0;
      end
      if (sclk) high_run++;
      if (!sclk && p_sclk) begin
        vectors++;
        if (high_run != int'(CLK_DIV)) begin
          miscompares++; $display("FAIL sclk_high_len: %0d cycles, required %0d", high_run, CLK_DIV);
        end
      end
      if (ncs && !p_ncs && in_frame) begin
        vectors += 3;
        if (nbits != 16) begin
          miscompares++; $display("FAIL sclk_rises: %0d, required 16", nbits);
        end
        if (low_len != int'(NCS_LOW)) begin
          miscompares++; $display("FAIL ncs_low_len: %0d, required %0d", low_len, NCS_LOW);
        end
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL frame_unexpected: got %h, scoreboard empty", shv);
        end else begin
          got = exp_q.pop_front();
          if (shv !== got) begin
            miscompares++; $display("FAIL frame: got %h, required %h", shv, got);
          end
        end
        regs[shv[14:8]] = shv[7:0];
        frames_done++; gap_len = 0; in_frame = 1'b0;
      end
      if (ncs) gap_len++;
      p_sclk = sclk; p_ncs = ncs; p_copi = copi;
    end
  end

  // Raise one requester and hold it until granted, then release after the accepting edge.
  task automatic drive_req(input bit is_b, input logic [6:0] addr, input logic [7:0] data);
    int n = 0;
    if (is_b) begin b_valid = 1'b1; b_addr = addr; b_data = data; end
    else      begin a_valid = 1'b1; a_addr = addr; a_data = data; end
    #1;
    while (!(is_b ? b_ready : a_ready) && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) begin
      miscompares++; $display("FAIL ready_timeout: requester %s never granted", is_b ? "B" : "A");
      a_valid = 1'b0; b_valid = 1'b0;
      return;
    end
    if (addr <= 7'd4) exp_q.push_back({1'b1, addr, data});
    last_b_model = is_b;
    @(posedge clk); #1;
    if (is_b) b_valid = 1'b0; else a_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_done < target && n < 2000) begin @(negedge clk); #1; n++; end
    if (frames_done < target) begin
      miscompares++; $display("FAIL frame_timeout: %0d frames seen, required %0d", frames_done, target);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin @(negedge clk); #1; n++; end
    if (busy) begin miscompares++; $display("FAIL idle_timeout: busy stuck at 1"); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors += 8;
    if (ncs !== 1'b1)  begin miscompares++; $display("FAIL rst_ncs: %b, required 1", ncs); end
    if (sclk !== 1'b0) begin miscompares++; $display("FAIL rst_sclk: %b, required 0", sclk); end
    if (copi !== 1'b0) begin miscompares++; $display("FAIL rst_copi: %b, required 0", copi); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: %b, required 0", busy); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: %b, required 0", done); end
    if (err !== 1'b0)  begin miscompares++; $display("FAIL rst_err: %b, required 0", err); end
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      miscompares++; $display("FAIL rst_ready: a=%b b=%b, required 0 0", a_ready, b_ready);
    end
    if (s_ncs !== 1'b1) begin miscompares++; $display("FAIL rst_s_ncs: %b, required 1", s_ncs); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    int base = frames_done;
    drive_req(1'b0, 7'h04, 8'h80);
    vectors += 2;
    if (ncs !== 1'b0)  begin miscompares++; $display("FAIL single_ncs_fall: %b, required 0", ncs); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: %b, required 1", busy); end
    wait_frames(base + 1);
    repeat (IDLE_GAP - 1) @(negedge clk);
    vectors += 1;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL gap_busy: %b, required 1", busy); end
    @(negedge clk);
    vectors += 1;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL gap_exit_busy: %b, required 0", busy); end
  endtask

  task automatic test_contention();
    int  base = frames_done;
    int  n;
    bit  exp_b;
    wait_idle();
    a_valid = 1'b1; a_addr = 7'h00; a_data = 8'hFF;
    b_valid = 1'b1; b_addr = 7'h01; b_data = 8'h0F;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(a_ready || b_ready) && n < 400) begin @(negedge clk); n++; end
      exp_b = !last_b_model;
      vectors++;
      if (n >= 400 || b_ready !== exp_b || a_ready !== !exp_b) begin
        miscompares++; $display("FAIL rr_grant[%0d]: a_ready=%b b_ready=%b, required b=%b", k, a_ready, b_ready, exp_b);
      end
      exp_q.push_back(exp_b ? 16'h810F : 16'h80FF);
      last_b_model = exp_b;
      @(posedge clk); #1;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    wait_frames(base + 4);
  endtask

  task automatic test_illegal();
    int base;
    wait_idle();
    repeat (IDLE_GAP + 1) @(negedge clk);
    base = frames_done;
    b_valid = 1'b1; b_addr = 7'h05; b_data = 8'h33;
    #1;
    vectors++;
    if (b_ready !== 1'b1) begin miscompares++; $display("FAIL illegal_ready: %b, required 1", b_ready); end
    @(posedge clk); #1;
    last_b_model = 1'b1;
    b_valid = 1'b0;
    a_valid = 1'b1; a_addr = 7'h01; a_data = 8'h5A;
    @(negedge clk);
    vectors += 4;
    if (err !== 1'b1)     begin miscompares++; $display("FAIL illegal_err: %b, required 1", err); end
    if (ncs !== 1'b1)     begin miscompares++; $display("FAIL illegal_ncs: %b, required 1", ncs); end
    if (busy !== 1'b0)    begin miscompares++; $display("FAIL illegal_busy: %b, required 0", busy); end
    if (a_ready !== 1'b1) begin miscompares++; $display("FAIL illegal_next_ready: %b, required 1", a_ready); end
    exp_q.push_back(16'h815A);
    last_b_model = 1'b0;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    vectors += 2;
    if (err !== 1'b0) begin miscompares++; $display("FAIL illegal_err_once: %b, required 0", err); end
    if (ncs !== 1'b0) begin miscompares++; $display("FAIL illegal_follow_ncs: %b, required 0", ncs); end
    wait_frames(base + 1);
  endtask

  task automatic test_reset_mid_frame();
    int base;
    int n = 0;
    wait_idle();
    drive_req(1'b0, 7'h02, 8'h3C);
    while (nbits < 7 && n < 400) begin @(negedge clk); #1; n++; end
    #2;
    rst_n = 1'b0;
    #1;
    vectors += 3;
    if (ncs !== 1'b1)  begin miscompares++; $display("FAIL abort_ncs: %b, required 1", ncs); end
    if (sclk !== 1'b0) begin miscompares++; $display("FAIL abort_sclk: %b, required 0", sclk); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: %b, required 0", busy); end
    exp_q.delete();
    last_b_model = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = frames_done;
    drive_req(1'b0, 7'h03, 8'h77);
    wait_frames(base + 1);
  endtask

  task automatic test_integration();
    int base = frames_done;
    wait_idle();
    drive_req(1'b0, 7'h00, 8'hFF);
    drive_req(1'b1, 7'h02, 8'hFF);
    drive_req(1'b0, 7'h04, 8'h80);
    wait_frames(base + 3);
    vectors += 3;
    if (regs[0] !== 8'hFF) begin miscompares++; $display("FAIL en_reg_out_7_0: %h, required ff", regs[0]); end
    if (regs[2] !== 8'hFF) begin miscompares++; $display("FAIL en_reg_pwm_7_0: %h, required ff", regs[2]); end
    if (regs[4] !== 8'h80) begin miscompares++; $display("FAIL pwm_duty_cycle: %h, required 80", regs[4]); end
  endtask

  task automatic test_param_sweep();
    int          n = 0, low = 0, bits = 0, hrun = 0, bad_high = 0;
    logic        ps = 1'b0;
    logic [15:0] cap = 16'h0, want;
    @(negedge clk);
    s_valid = 1'b1; s_addr = 7'h03; s_data = 8'h5A;
    exp_s.push_back(16'h835A);
    #1;
    while (!s_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    s_valid = 1'b0;
    vectors++;
    if (s_ncs !== 1'b0) begin miscompares++; $display("FAIL sweep_ncs_fall: %b, required 0", s_ncs); end
    n = 0;
    while (n < 200) begin
      @(negedge clk); n++;
      if (s_ncs) break;
      low++;
      if (s_sclk && !ps) begin cap = {cap[14:0], s_copi}; bits++; hrun = 0; end
      if (s_sclk) hrun++;
      if (!s_sclk && ps && hrun != 2) bad_high++;
      ps = s_sclk;
    end
    want = exp_s.pop_front();
    vectors += 5;
    if (cap !== want)     begin miscompares++; $display("FAIL sweep_frame: %h, required %h", cap, want); end
    if (low != int'(S_NCS_LOW)) begin miscompares++; $display("FAIL sweep_ncs_low: %0d, required %0d", low, S_NCS_LOW); end
    if (bits != 16)       begin miscompares++; $display("FAIL sweep_rises: %0d, required 16", bits); end
    if (bad_high != 0)    begin miscompares++; $display("FAIL sweep_half_period: %0d bad high phases, required 0", bad_high); end
    if (s_done !== 1'b1)  begin miscompares++; $display("FAIL sweep_done: %b, required 1", s_done); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    s_valid = 1'b0; s_addr = '0; s_data = '0;
    s_b_valid = 1'b0; s_b_addr = '0; s_b_data = '0;
    test_reset();
    test_single_write();
    test_contention();
    test_illegal();
    test_reset_mid_frame();
    test_integration();
    test_param_sweep();
    repeat (10) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_leftover: %0d frames never seen, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
